// File: rtl/exe_stage_module_pkg.sv
// Shared widths, exec-command and shift-type codes, and NZCV layout for the
// execute stage.
package exe_stage_module_pkg;

    localparam int ADDRESS_LEN               = 32;
    localparam int REGISTER_FILE_LEN         = 32;
    localparam int EXEC_COMMAND_LEN          = 4;
    localparam int SHIFT_OPERAND_LEN         = 12;
    localparam int SIGNED_IMM_LEN            = 24;
    localparam int REGISTER_FILE_ADDRESS_LEN = 4;
    localparam int STATUS_REG_LEN            = 4;

    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_MOV = 4'b0001;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_ADD = 4'b0010;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_ADC = 4'b0011;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_SUB = 4'b0100;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_SBC = 4'b0101;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_AND = 4'b0110;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_ORR = 4'b0111;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_EOR = 4'b1000;
    localparam logic [EXEC_COMMAND_LEN-1:0] CMD_MVN = 4'b1001;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    localparam logic [1:0] SRC_MEM_ALU = 2'b01;
    localparam logic [1:0] SRC_WB      = 2'b10;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    function automatic logic [REGISTER_FILE_LEN-1:0] ror32(
        input logic [REGISTER_FILE_LEN-1:0] value,
        input logic [4:0]                   amount
    );
        logic [2*REGISTER_FILE_LEN-1:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[REGISTER_FILE_LEN-1:0];
    endfunction

endpackage

// File: rtl/exe_stage_module_if.sv
// ID/EXE inputs and EXE/MEM, IF, ID return paths of the execute stage.
interface exe_stage_module_if;
    import exe_stage_module_pkg::*;

    logic                                 wb_en_in;
    logic                                 mem_r_en_in;
    logic                                 mem_w_en_in;
    logic                                 b_in;
    logic                                 s_in;
    logic                                 imm_in;
    logic [EXEC_COMMAND_LEN-1:0]          exec_cmd_in;
    logic [ADDRESS_LEN-1:0]               pc_in;
    logic [REGISTER_FILE_LEN-1:0]         val_r_n_in;
    logic [REGISTER_FILE_LEN-1:0]         val_r_m_in;
    logic [SHIFT_OPERAND_LEN-1:0]         shift_operand_in;
    logic [SIGNED_IMM_LEN-1:0]            signed_imm_24_in;
    logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_in;
    logic [1:0]                           sel_src_1;
    logic [1:0]                           sel_src_2;
    logic [REGISTER_FILE_LEN-1:0]         wb_value;

    logic                                 branch_taken;
    logic [ADDRESS_LEN-1:0]               branch_address;
    logic [STATUS_REG_LEN-1:0]            status_reg_out;
    logic                                 wb_en_out;
    logic                                 mem_r_en_out;
    logic                                 mem_w_en_out;
    logic [REGISTER_FILE_LEN-1:0]         alu_result_out;
    logic [REGISTER_FILE_LEN-1:0]         val_r_m_out;
    logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_out;

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        input  exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
        input  signed_imm_24_in, dest_in, sel_src_1, sel_src_2, wb_value,
        output branch_taken, branch_address, status_reg_out,
        output wb_en_out, mem_r_en_out, mem_w_en_out,
        output alu_result_out, val_r_m_out, dest_out
    );

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        output exec_cmd_in, pc_in, val_r_n_in, val_r_m_in, shift_operand_in,
        output signed_imm_24_in, dest_in, sel_src_1, sel_src_2, wb_value,
        input  branch_taken, branch_address, status_reg_out,
        input  wb_en_out, mem_r_en_out, mem_w_en_out,
        input  alu_result_out, val_r_m_out, dest_out
    );

endinterface

// File: rtl/exe_stage_module_val2_generator.sv
// Second-operand generator: rotated immediate, sign-extended memory offset,
// or immediate-shifted register.
module val2_generator
    import exe_stage_module_pkg::*;
(
    input  logic                         imm,
    input  logic                         mem_en,
    input  logic [SHIFT_OPERAND_LEN-1:0] shift_operand,
    input  logic [REGISTER_FILE_LEN-1:0] val_r_m,
    output logic [REGISTER_FILE_LEN-1:0] val2
);

    logic [4:0]                   imm_rotate;
    logic [4:0]                   shift_amount;
    logic signed [REGISTER_FILE_LEN-1:0] val_r_m_signed;
    logic                         unused_reg_shift_bit;

    assign imm_rotate     = {shift_operand[11:8], 1'b0};
    assign shift_amount   = shift_operand[11:7];
    assign val_r_m_signed = val_r_m;
    // Shift amount always comes from the immediate field; bit 4 is ignored.
    assign unused_reg_shift_bit = shift_operand[4];

    always_comb begin
        // NOTE: every path assigns val2 before the branches so no latch is inferred.
        val2 = val_r_m;
        if (imm) begin
            val2 = ror32({24'b0, shift_operand[7:0]}, imm_rotate);
        end else if (mem_en) begin
            val2 = {{(REGISTER_FILE_LEN-SHIFT_OPERAND_LEN){shift_operand[11]}}, shift_operand};
        end else begin
            case (shift_type_e'(shift_operand[6:5]))
                SHIFT_LSL: val2 = val_r_m << shift_amount;
                SHIFT_LSR: val2 = val_r_m >> shift_amount;
                SHIFT_ASR: val2 = val_r_m_signed >>> shift_amount;
                SHIFT_ROR: val2 = ror32(val_r_m, shift_amount);
                default:   val2 = val_r_m;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_module.sv
// Execute stage: operand forwarding, Val2, ALU, NZCV register, branch target and
// EXE/MEM register. Macro FORWARDING_EN enables the sel_src_1/sel_src_2 muxes.
module exe_stage_module
    import exe_stage_module_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    exe_stage_module_if.slave bus
);

    logic [REGISTER_FILE_LEN-1:0] op1;
    logic [REGISTER_FILE_LEN-1:0] fwd_m;
    logic [REGISTER_FILE_LEN-1:0] val2;
    logic [REGISTER_FILE_LEN-1:0] alu_result;
    logic [REGISTER_FILE_LEN-1:0] addend_b;
    logic [REGISTER_FILE_LEN:0]   sum;
    logic                         add_cin;
    logic                         is_arith;
    logic                         cmd_valid;
    nzcv_t                        status_q;
    nzcv_t                        status_next;

`ifdef FORWARDING_EN
    always_comb begin
        case (bus.sel_src_1)
            SRC_MEM_ALU: op1 = bus.alu_result_out;
            SRC_WB:      op1 = bus.wb_value;
            default:     op1 = bus.val_r_n_in;
        endcase
        case (bus.sel_src_2)
            SRC_MEM_ALU: fwd_m = bus.alu_result_out;
            SRC_WB:      fwd_m = bus.wb_value;
            default:     fwd_m = bus.val_r_m_in;
        endcase
    end
`else
    logic unused_forwarding;
    assign op1   = bus.val_r_n_in;
    assign fwd_m = bus.val_r_m_in;
    assign unused_forwarding = &{1'b0, bus.sel_src_1, bus.sel_src_2, bus.wb_value};
`endif

    val2_generator u_val2_generator (
        .imm           (bus.imm_in),
        .mem_en        (bus.mem_r_en_in | bus.mem_w_en_in),
        .shift_operand (bus.shift_operand_in),
        .val_r_m       (fwd_m),
        .val2          (val2)
    );

    // Subtraction is op1 + ~Val2 + carry so one 33-bit adder covers all four arithmetic ops.
    always_comb begin
        alu_result = '0;
        addend_b   = '0;
        add_cin    = 1'b0;
        is_arith   = 1'b0;
        cmd_valid  = 1'b1;
        case (bus.exec_cmd_in)
            CMD_MOV: alu_result = val2;
            CMD_MVN: alu_result = ~val2;
            CMD_ADD: begin is_arith = 1'b1; addend_b = val2;  add_cin = 1'b0;       end
            CMD_ADC: begin is_arith = 1'b1; addend_b = val2;  add_cin = status_q.c; end
            CMD_SUB: begin is_arith = 1'b1; addend_b = ~val2; add_cin = 1'b1;       end
            CMD_SBC: begin is_arith = 1'b1; addend_b = ~val2; add_cin = status_q.c; end
            CMD_AND: alu_result = op1 & val2;
            CMD_ORR: alu_result = op1 | val2;
            CMD_EOR: alu_result = op1 ^ val2;
            default: cmd_valid  = 1'b0;
        endcase

        sum = {1'b0, op1} + {1'b0, addend_b} + {{REGISTER_FILE_LEN{1'b0}}, add_cin};
        if (is_arith) begin
            alu_result = sum[REGISTER_FILE_LEN-1:0];
        end

        status_next = status_q;
        if (cmd_valid) begin
            status_next.n = alu_result[REGISTER_FILE_LEN-1];
            status_next.z = (alu_result == '0);
            if (is_arith) begin
                status_next.c = sum[REGISTER_FILE_LEN];
                status_next.v = (op1[REGISTER_FILE_LEN-1] == addend_b[REGISTER_FILE_LEN-1]) &&
                                (sum[REGISTER_FILE_LEN-1] != op1[REGISTER_FILE_LEN-1]);
            end
        end
    end

    assign bus.branch_taken   = bus.b_in;
    assign bus.branch_address = bus.pc_in +
        {{(ADDRESS_LEN-SIGNED_IMM_LEN-2){bus.signed_imm_24_in[SIGNED_IMM_LEN-1]}},
         bus.signed_imm_24_in, 2'b00};
    assign bus.status_reg_out = status_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            status_q           <= '0;
            bus.wb_en_out      <= 1'b0;
            bus.mem_r_en_out   <= 1'b0;
            bus.mem_w_en_out   <= 1'b0;
            bus.alu_result_out <= '0;
            bus.val_r_m_out    <= '0;
            bus.dest_out       <= '0;
        end else begin
            if (bus.s_in) begin
                status_q <= status_next;
            end
            bus.wb_en_out      <= bus.wb_en_in;
            bus.mem_r_en_out   <= bus.mem_r_en_in;
            bus.mem_w_en_out   <= bus.mem_w_en_in;
            bus.alu_result_out <= alu_result;
            bus.val_r_m_out    <= fwd_m;
            bus.dest_out       <= bus.dest_in;
        end
    end

endmodule

// File: tb/tb_exe_stage_module.sv
// Scoreboard bench for exe_stage_module: randomized instructions against an
// arithmetic reference model, plus the directed corner cases.
module tb_exe_stage_module;
    import exe_stage_module_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_module_if bus ();

    exe_stage_module dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wb, mr, mw, b, s, imm;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic [11:0] so;
        logic [23:0] off;
        logic [3:0]  dest;
        logic [1:0]  s1, s2;
        logic [31:0] wbv;
    } instr_t;

    typedef struct {
        logic        wb, mr, mw;
        logic [31:0] alu, rm;
        logic [3:0]  dest, nzcv;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  m_flags  = 4'b0;
    logic [31:0] m_prev   = 32'b0;

    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_ror(input logic [31:0] v, input int n);
        if (n == 0) return v;
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] m_val2(input instr_t t, input logic [31:0] fm);
        int amt;
        logic signed [31:0] sv;
        if (t.imm) return m_ror({24'b0, t.so[7:0]}, 2 * int'(t.so[11:8]));
        if (t.mr || t.mw) return {{20{t.so[11]}}, t.so};
        amt = int'(t.so[11:7]);
        sv  = fm;
        case (t.so[6:5])
            2'd0:    return fm << amt;
            2'd1:    return fm >> amt;
            2'd2:    return sv >>> amt;
            default: return m_ror(fm, amt);
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] wbv);
`ifdef FORWARDING_EN
        if (sel == 2'b01) return m_prev;
        if (sel == 2'b10) return wbv;
`endif
        return reg_val;
    endfunction

    task automatic model(input instr_t t, output exp_t e);
        logic [31:0] op1, fm, v2, res;
        logic        c, v, valid;
        longint      k, a_u, b_u, a_s, b_s, s;
        op1   = m_fwd(t.s1, t.rn, t.wbv);
        fm    = m_fwd(t.s2, t.rm, t.wbv);
        v2    = m_val2(t, fm);
        c     = m_flags[1];
        v     = m_flags[0];
        valid = 1'b1;
        a_u   = longint'({32'd0, op1});
        b_u   = longint'({32'd0, v2});
        a_s   = longint'($signed(op1));
        b_s   = longint'($signed(v2));
        res   = 32'd0;
        case (t.cmd)
            4'h1: res = v2;
            4'h9: res = ~v2;
            4'h2, 4'h3: begin
                k   = (t.cmd == 4'h3) ? longint'(m_flags[1]) : 64'd0;
                res = op1 + v2 + 32'(k);
                c   = (a_u + b_u + k) > 64'hFFFF_FFFF;
                s   = a_s + b_s + k;
                v   = (s > S_MAX) || (s < S_MIN);
            end
            4'h4, 4'h5: begin
                k   = (t.cmd == 4'h4) ? 64'd0 : 64'd1 - longint'(m_flags[1]);
                res = op1 - v2 - 32'(k);
                c   = a_u >= b_u + k;
                s   = a_s - b_s - k;
                v   = (s > S_MAX) || (s < S_MIN);
            end
            4'h6: res = op1 & v2;
            4'h7: res = op1 | v2;
            4'h8: res = op1 ^ v2;
            default: valid = 1'b0;
        endcase
        e.wb   = t.wb;
        e.mr   = t.mr;
        e.mw   = t.mw;
        e.alu  = res;
        e.rm   = fm;
        e.dest = t.dest;
        e.nzcv = (t.s && valid) ? {res[31], res == 32'd0, c, v} : m_flags;
        m_flags = e.nzcv;
        m_prev  = res;
    endtask

    task automatic zero_inputs();
        bus.wb_en_in = 0; bus.mem_r_en_in = 0; bus.mem_w_en_in = 0; bus.b_in = 0;
        bus.s_in = 0; bus.imm_in = 0; bus.exec_cmd_in = 0; bus.pc_in = 0;
        bus.val_r_n_in = 0; bus.val_r_m_in = 0; bus.shift_operand_in = 0;
        bus.signed_imm_24_in = 0; bus.dest_in = 0; bus.sel_src_1 = 0;
        bus.sel_src_2 = 0; bus.wb_value = 0;
    endtask

    task automatic issue(input instr_t t);
        exp_t               e;
        logic signed [31:0] off32;
        @(negedge clk);
        bus.wb_en_in = t.wb; bus.mem_r_en_in = t.mr; bus.mem_w_en_in = t.mw;
        bus.b_in = t.b; bus.s_in = t.s; bus.imm_in = t.imm; bus.exec_cmd_in = t.cmd;
        bus.pc_in = t.pc; bus.val_r_n_in = t.rn; bus.val_r_m_in = t.rm;
        bus.shift_operand_in = t.so; bus.signed_imm_24_in = t.off; bus.dest_in = t.dest;
        bus.sel_src_1 = t.s1; bus.sel_src_2 = t.s2; bus.wb_value = t.wbv;
        model(t, e);
        sb_q.push_back(e);
        #1;
        off32 = $signed(t.off);
        check("branch_taken", {31'd0, bus.branch_taken}, {31'd0, t.b});
        check("branch_address", bus.branch_address, t.pc + off32 * 4);
    endtask

    function automatic instr_t blank();
        instr_t t;
        t.wb = 0; t.mr = 0; t.mw = 0; t.b = 0; t.s = 0; t.imm = 0; t.cmd = 0;
        t.pc = 0; t.rn = 0; t.rm = 0; t.so = 0; t.off = 0; t.dest = 0;
        t.s1 = 0; t.s2 = 0; t.wbv = 0;
        return t;
    endfunction

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t      = blank();
        t.wb   = 1'($urandom_range(0, 1));
        t.mr   = ($urandom_range(0, 7) == 0);
        t.mw   = ($urandom_range(0, 7) == 0);
        t.b    = 1'($urandom_range(0, 1));
        t.s    = 1'($urandom_range(0, 1));
        t.imm  = ($urandom_range(0, 2) == 0);
        t.cmd  = 4'($urandom_range(0, 15));
        t.pc   = $urandom;
        t.rn   = pick_word();
        t.rm   = pick_word();
        t.so   = 12'($urandom);
        t.off  = 24'($urandom);
        t.dest = 4'($urandom);
        t.s1   = 2'($urandom);
        t.s2   = 2'($urandom);
        t.wbv  = pick_word();
        return t;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, {28'd0, bus.status_reg_out}, 32'd0);
        check({tag, "_alu"}, bus.alu_result_out, 32'd0);
        check({tag, "_rm"}, bus.val_r_m_out, 32'd0);
        check({tag, "_dest"}, {28'd0, bus.dest_out}, 32'd0);
        check({tag, "_ctrl"}, {29'd0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out}, 32'd0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_alu", bus.alu_result_out, e.alu);
            check("sb_val_r_m", bus.val_r_m_out, e.rm);
            check("sb_dest", {28'd0, bus.dest_out}, {28'd0, e.dest});
            check("sb_ctrl", {29'd0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out},
                  {29'd0, e.wb, e.mr, e.mw});
            check("sb_status", {28'd0, bus.status_reg_out}, {28'd0, e.nzcv});
        end
    end

    initial begin
        instr_t t;
        rst = 1'b1;
        zero_inputs();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        t = blank(); t.cmd = CMD_ADD; t.rn = 32'h7FFF_FFFF; t.imm = 1; t.so = 12'h001; t.s = 1;
        issue(t);
        @(posedge clk); #1;
        check("add_ovf_result", bus.alu_result_out, 32'h8000_0000);
        check("add_ovf_nzcv", {28'd0, bus.status_reg_out}, 32'b1001);

        t = blank(); t.cmd = CMD_SUB; t.rn = 5; t.imm = 1; t.so = 12'h005; t.s = 1;
        issue(t);
        @(posedge clk); #1;
        check("sub_eq_result", bus.alu_result_out, 32'd0);
        check("sub_eq_nzcv", {28'd0, bus.status_reg_out}, 32'b0110);

        t = blank(); t.cmd = CMD_SBC; t.rn = 5; t.imm = 1; t.so = 12'h003; t.s = 1;
        issue(t);
        @(posedge clk); #1;
        check("sbc_result", bus.alu_result_out, 32'd2);

        t = blank(); t.cmd = CMD_MOV; t.rm = 32'h8000_0000; t.so = 12'b001001000000;
        issue(t);
        @(posedge clk); #1;
        check("asr4_val2", bus.alu_result_out, 32'hF800_0000);

        t = blank(); t.cmd = CMD_MOV; t.rm = 32'h0000_00FF; t.so = 12'b010001100000;
        issue(t);
        @(posedge clk); #1;
        check("ror8_val2", bus.alu_result_out, 32'hFF00_0000);

        t = blank(); t.cmd = CMD_MOV; t.imm = 1; t.so = 12'h2FF;
        issue(t);
        @(posedge clk); #1;
        check("imm_rotate_val2", bus.alu_result_out, 32'hF000_000F);

        t = blank(); t.cmd = CMD_ADD; t.mw = 1; t.rn = 32'h0000_1000; t.so = 12'hFFC;
        issue(t);
        @(posedge clk); #1;
        check("mem_offset_neg4", bus.alu_result_out, 32'h0000_0FFC);

        t = blank(); t.b = 1; t.pc = 32'h100; t.off = 24'hFFFFFE;
        issue(t);
        check("branch_back_8", bus.branch_address, 32'h0000_00F8);

        t = blank(); t.cmd = CMD_MOV; t.imm = 1; t.so = 12'h010;
        issue(t);
        t = blank(); t.cmd = CMD_ADD; t.rn = 32'h55; t.s1 = 2'b01; t.imm = 1; t.so = 12'h001;
        issue(t);
        @(posedge clk); #1;
`ifdef FORWARDING_EN
        check("fwd_mem_alu", bus.alu_result_out, 32'h0000_0011);
`else
        check("no_fwd_regfile", bus.alu_result_out, 32'h0000_0056);
`endif

        repeat (300) issue(rand_instr());

        t = blank(); t.cmd = CMD_MVN; t.s = 1; t.wb = 1; t.dest = 4'd7; t.rm = 32'h1234;
        issue(t);
        @(posedge clk); #3;
        rst = 1'b1;
        zero_inputs();
        #1;
        check_all_zero("midrun_reset");
        sb_q.delete();
        m_flags = 4'b0;
        m_prev  = 32'b0;
        @(negedge clk);
        rst = 1'b0;

        t = blank(); t.cmd = CMD_ADC; t.rn = 1; t.imm = 1; t.so = 12'h001; t.s = 1;
        issue(t);
        @(posedge clk); #1;
        check("adc_after_reset", bus.alu_result_out, 32'd2);
        check("adc_after_reset_nzcv", {28'd0, bus.status_reg_out}, 32'b0000);

        repeat (100) issue(rand_instr());

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
